button_pulse_ctrl: RTL and testbench
====================================

# button_pulse_ctrl

Front-end control stage that sits directly upstream of the 4-bit up/down counter. It synchronises and debounces three raw push-button inputs (step, load, mode) and produces the counter's control signals: a single-cycle `en` pulse per step press, a single-cycle `load` pulse per load press, and a `mode` level that toggles on each mode press. Raw mechanical bounce never reaches the counter.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a level change; must be ≥ 1.
- `MODE_INIT`, default 1: reset value of `mode` (1 = count up, 0 = count down).
- `REPEAT_DELAY`, default 64: hold cycles before auto-repeat starts. Used only with `BTN_AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, default 8: cycles between repeated `en` pulses. Used only with `BTN_AUTO_REPEAT_EN`.
- `clk`  in  1  single system clock; rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `btn_step`  in  1  raw step button, asynchronous to `clk`, active high.
- `btn_load`  in  1  raw load button, asynchronous, active high.
- `btn_mode`  in  1  raw mode button, asynchronous, active high.
- `en`  out  1  registered one-cycle count-enable pulse to the counter.
- `load`  out  1  registered one-cycle load pulse to the counter.
- `mode`  out  1  registered direction level to the counter.

## Operation
- Each button gets a 2-flop synchroniser (reset to 0) followed by its own debounce FSM.
- FSM states: IDLE → PRESS_WAIT → PRESSED → RELEASE_WAIT → IDLE.
- IDLE: synchronised input = 1 → PRESS_WAIT; the counter is cleared.
- PRESS_WAIT: the counter increments while the input is 1. If the input returns to 0, go back to IDLE (the count restarts on the next rise). When the count reaches `DEBOUNCE_CYCLES`, go to PRESSED and issue one accept strobe.
- PRESSED: input = 0 → RELEASE_WAIT.
- RELEASE_WAIT: requires `DEBOUNCE_CYCLES` consecutive 0s to reach IDLE. Any 1 returns to PRESSED with no new strobe.
- Release never generates a strobe.
- Counter width is $clog2(`DEBOUNCE_CYCLES`+1). The counter saturates and never wraps.
- Step strobe → `en` = 1 for exactly one cycle.
- Load strobe → `load` = 1 for exactly one cycle.
- Mode strobe → `mode` inverts once.
- Simultaneous strobes:
  - Load and step in the same cycle: `load` pulses and that `en` pulse is dropped, not deferred.
  - Mode and step in the same cycle: `mode` toggles and `en` pulses on the same edge, so the counter steps in the new direction.
  - Mode and load in the same cycle: both take effect.
- Reset is asynchronous: `en` = 0, `load` = 0, `mode` = `MODE_INIT`, all FSMs in IDLE, all counters 0, synchronisers 0.
- Reset asserted mid-debounce aborts that debounce with no pulse.
- A button held through reset deassertion counts as a new press after full debounce.

## Timing
- Press latency: if a raw input rises and stays high, the output pulse is high during the cycle after the (`DEBOUNCE_CYCLES`+3)th rising edge following the raw change. This is 2 synchroniser edges + `DEBOUNCE_CYCLES` + 1 output register.
- Minimum spacing between two accepted presses of one button is 2×`DEBOUNCE_CYCLES`+2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- `en` and `load` are never high for two consecutive cycles from a single press, except auto-repeat `en` pulses, which are spaced by `REPEAT_PERIOD`.

## Configuration
- Macro: `BTN_AUTO_REPEAT_EN`.
- Defined:
  - The step FSM counts cycles while in PRESSED.
  - After `REPEAT_DELAY` cycles from the first `en` pulse, it issues further `en` pulses every `REPEAT_PERIOD` cycles for as long as the button stays pressed. Time spent in RELEASE_WAIT is not counted.
  - Repeat pulses obey the same load-priority rule.
  - Release or reset stops repeating immediately.
- Undefined: the repeat logic and the repeat parameters are absent. Exactly one `en` pulse is issued per accepted press.
- The load and mode buttons never auto-repeat.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `MODE_INIT`=1.

1. Reset value and single step press:
   - Hold `resetn`=0 → `en`=0, `load`=0, `mode`=1.
   - Release reset, then hold `btn_step` high 20 cycles → exactly one `en` pulse, in the cycle after the 7th edge following the rise.
   - Release → no further pulse.
2. Bounce rejection: toggle `btn_step` 1,0,1,0 with 2 cycles per level, then hold high 10 cycles → exactly one `en` pulse, 7 edges after the final rise.
3. Load and step simultaneous: drive `btn_load` and `btn_step` identically high 10 cycles → `load`=1 for one cycle, `en` stays 0 throughout.
4. Mode toggle: three clean mode presses separated by 12 low cycles → `mode` goes 1→0→1→0, one change per press, and none on release.
5. Reset mid-debounce: raise `btn_step`, pull `resetn` low 3 cycles later for 2 cycles, and keep the button high → no pulse during the aborted debounce; one `en` pulse 7 edges after `resetn` rises.
6. Auto-repeat (with `BTN_AUTO_REPEAT_EN`, `REPEAT_DELAY`=16, `REPEAT_PERIOD`=4): hold `btn_step` 40 cycles → first `en`, then a second pulse 16 cycles later, then pulses every 4 cycles until release.
   - Without the macro, the same stimulus → exactly one pulse.

Source files
------------

// File: rtl/button_pulse_ctrl_if.sv
// button_pulse_ctrl_if
//   Groups the raw push-button inputs and the counter control outputs of
//   button_pulse_ctrl into one bundle.
//
//   Signals:
//     btn_step  raw step button (asynchronous, active high)
//     btn_load  raw load button (asynchronous, active high)
//     btn_mode  raw mode button (asynchronous, active high)
//     en        one-cycle count-enable pulse to the counter
//     load      one-cycle load pulse to the counter
//     mode      direction level to the counter (1 = up, 0 = down)
//
//   Modports:
//     master  drives the buttons, observes the counter controls
//     slave   the controller: reads the buttons, drives the counter controls
interface button_pulse_ctrl_if;
    logic btn_step;
    logic btn_load;
    logic btn_mode;
    logic en;
    logic load;
    logic mode;

    modport master (
        output btn_step,
        output btn_load,
        output btn_mode,
        input  en,
        input  load,
        input  mode
    );

    modport slave (
        input  btn_step,
        input  btn_load,
        input  btn_mode,
        output en,
        output load,
        output mode
    );
endinterface

// File: rtl/button_pulse_ctrl.sv
// button_pulse_ctrl
//   Synchronises and debounces the step, load and mode push buttons and turns
//   accepted presses into control signals for the 4-bit up/down counter:
//   a one-cycle en pulse per step press, a one-cycle load pulse per load
//   press, and a mode level that toggles on each mode press.
//
//   Ports:
//     clk     system clock, rising edge
//     resetn  asynchronous active-low reset
//     bus     button_pulse_ctrl_if.slave (btn_step/btn_load/btn_mode in,
//             en/load/mode out; all outputs registered)
//
//   Parameters:
//     DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 1)
//     MODE_INIT        reset value of mode
//     REPEAT_DELAY     hold cycles from the first en pulse to the first
//                      repeat (only with BTN_AUTO_REPEAT_EN)
//     REPEAT_PERIOD    cycles between repeat en pulses (only with
//                      BTN_AUTO_REPEAT_EN)
//
//   Build option:
//     BTN_AUTO_REPEAT_EN  when defined, a held step button auto-repeats en.
//                         When undefined the repeat logic and its parameters
//                         do not exist and each press gives exactly one en.

// Per-button synchroniser + debounce FSM.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   IDLE         | button released and stable
//   PRESS_WAIT   | input high, counting stable high cycles
//   PRESSED      | press accepted, waiting for the input to fall
//   RELEASE_WAIT | input low, counting stable low cycles
//
// The first cycle that sees the new level (the transition out of IDLE or
// PRESSED) counts as one of the DEBOUNCE_CYCLES, so the wait states leave
// when the counter sits at DEBOUNCE_CYCLES-1 and sees the level once more.
module button_pulse_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
`ifdef BTN_AUTO_REPEAT_EN
    ,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 8
`endif
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw_i,
    output logic strobe_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [1:0]    sync_q;
    logic          btn_s;
    logic          accept;

    assign btn_s = sync_q[1];

    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= 2'b00;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TERM) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    // Bounce on release: back to PRESSED without a new strobe.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TERM) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                   : REPEAT_PERIOD;
            localparam int RW      = $clog2(RPT_MAX + 1);

            logic [RW-1:0] rpt_q, rpt_d;
            logic          rpt_fire;

            // Down-counter armed on the accept strobe. It only runs while the
            // button is held in PRESSED, so RELEASE_WAIT pauses it and a
            // falling input suppresses any further repeat at once.
            always_comb begin
                rpt_d    = rpt_q;
                rpt_fire = 1'b0;
                if (accept) begin
                    rpt_d = RW'(REPEAT_DELAY - 1);
                end else if ((state_q == PRESSED) && btn_s) begin
                    if (rpt_q == '0) begin
                        rpt_fire = 1'b1;
                        rpt_d    = RW'(REPEAT_PERIOD - 1);
                    end else begin
                        rpt_d = rpt_q - RW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    rpt_q <= '0;
                end else begin
                    rpt_q <= rpt_d;
                end
            end

            assign strobe_o = accept | rpt_fire;
        end else begin : g_no_repeat
            assign strobe_o = accept;
        end
    endgenerate
`else
    assign strobe_o = accept;
`endif

endmodule

module button_pulse_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit MODE_INIT       = 1'b1
`ifdef BTN_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 8
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    button_pulse_ctrl_if.slave  bus
);

    logic step_stb;
    logic load_stb;
    logic mode_stb;

    logic en_q,   en_d;
    logic load_q, load_d;
    logic mode_q, mode_d;

`ifdef BTN_AUTO_REPEAT_EN
    button_pulse_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_step_db (
        .clk      (clk),
        .resetn   (resetn),
        .raw_i    (bus.btn_step),
        .strobe_o (step_stb)
    );
`else
    button_pulse_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk      (clk),
        .resetn   (resetn),
        .raw_i    (bus.btn_step),
        .strobe_o (step_stb)
    );
`endif

    button_pulse_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk      (clk),
        .resetn   (resetn),
        .raw_i    (bus.btn_load),
        .strobe_o (load_stb)
    );

    button_pulse_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_mode_db (
        .clk      (clk),
        .resetn   (resetn),
        .raw_i    (bus.btn_mode),
        .strobe_o (mode_stb)
    );

    // Load wins over a coincident step: that en pulse is discarded rather
    // than held back, so the counter never steps right after being loaded
    // by the same press pair. Mode and step on the same edge both apply, so
    // the counter steps in the new direction.
    always_comb begin
        en_d   = step_stb & ~load_stb;
        load_d = load_stb;
        mode_d = mode_q ^ mode_stb;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q   <= 1'b0;
            load_q <= 1'b0;
            mode_q <= MODE_INIT;
        end else begin
            en_q   <= en_d;
            load_q <= load_d;
            mode_q <= mode_d;
        end
    end

    assign bus.en   = en_q;
    assign bus.load = load_q;
    assign bus.mode = mode_q;

endmodule

// File: tb/tb_button_pulse_ctrl.sv
module tb_button_pulse_ctrl;

    localparam int DEB  = 4;
    localparam int LAT  = DEB + 3;   // raw change -> output high, in edges
`ifdef BTN_AUTO_REPEAT_EN
    localparam int RD   = 16;
    localparam int RP   = 4;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;

    button_pulse_ctrl_if bus();

    button_pulse_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .MODE_INIT       (1'b1)
`ifdef BTN_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    int exp_en_q[$];
    int exp_load_q[$];
    int exp_mode_t_q[$];
    int exp_mode_v_q[$];
    logic mode_prev;

    task automatic check_val(input string tag, input int act, input int expected);
        n_checks++;
        if (act !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, expected, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: 1 time unit after each rising edge, pop the expected
    // event time for every pulse / mode change the DUT produces.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (resetn) begin
            if (bus.en === 1'b1) begin
                if (exp_en_q.size() == 0) check_val("en_unexpected", cyc, -1);
                else                      check_val("en_time", cyc, exp_en_q.pop_front());
            end
            if (bus.load === 1'b1) begin
                if (exp_load_q.size() == 0) check_val("load_unexpected", cyc, -1);
                else                        check_val("load_time", cyc, exp_load_q.pop_front());
            end
            if (bus.mode !== mode_prev) begin
                if (exp_mode_t_q.size() == 0) begin
                    check_val("mode_unexpected", cyc, -1);
                end else begin
                    check_val("mode_time", cyc, exp_mode_t_q.pop_front());
                    check_val("mode_val", int'(bus.mode), exp_mode_v_q.pop_front());
                end
            end
        end
        mode_prev = bus.mode;
    end

    initial begin
        int mexp;
        int t0;
        bus.btn_step = 1'b0;
        bus.btn_load = 1'b0;
        bus.btn_mode = 1'b0;
        resetn       = 1'b0;

        // 1. reset values, single clean step press
        cycles(3);
        check_val("rst_en",   int'(bus.en),   0);
        check_val("rst_load", int'(bus.load), 0);
        check_val("rst_mode", int'(bus.mode), 1);
        resetn = 1'b1;
        cycles(3);
        bus.btn_step = 1'b1;
        exp_en_q.push_back(cyc + LAT);
        cycles(20);
        bus.btn_step = 1'b0;
        cycles(20);
        check_val("s1_en_pending", exp_en_q.size(), 0);

        // 2. bounce rejection
        for (int i = 0; i < 4; i++) begin
            bus.btn_step = (i % 2 == 0);
            cycles(2);
        end
        bus.btn_step = 1'b1;
        exp_en_q.push_back(cyc + LAT);
        cycles(10);
        bus.btn_step = 1'b0;
        cycles(20);
        check_val("s2_en_pending", exp_en_q.size(), 0);

        // 3. load and step together: load only
        bus.btn_step = 1'b1;
        bus.btn_load = 1'b1;
        exp_load_q.push_back(cyc + LAT);
        cycles(10);
        bus.btn_step = 1'b0;
        bus.btn_load = 1'b0;
        cycles(20);
        check_val("s3_load_pending", exp_load_q.size(), 0);
        check_val("s3_en_pending",   exp_en_q.size(),   0);

        // 4. three mode presses: 1 -> 0 -> 1 -> 0
        mexp = 1;
        for (int i = 0; i < 3; i++) begin
            bus.btn_mode = 1'b1;
            mexp = 1 - mexp;
            exp_mode_t_q.push_back(cyc + LAT);
            exp_mode_v_q.push_back(mexp);
            cycles(8);
            bus.btn_mode = 1'b0;
            cycles(12);
        end
        cycles(8);
        check_val("s4_mode_pending", exp_mode_t_q.size(), 0);
        check_val("s4_mode_final",   int'(bus.mode), 0);

        // 5. reset in the middle of a step debounce, button kept high
        bus.btn_step = 1'b1;
        cycles(3);
        resetn = 1'b0;
        cycles(2);
        check_val("s5_mode_reset", int'(bus.mode), 1);
        resetn = 1'b1;
        exp_en_q.push_back(cyc + LAT);
        cycles(12);
        bus.btn_step = 1'b0;
        cycles(20);
        check_val("s5_en_pending", exp_en_q.size(), 0);

        // 6. long hold: one pulse, or auto-repeat when enabled
        bus.btn_step = 1'b1;
        t0 = cyc;
        exp_en_q.push_back(t0 + LAT);
`ifdef BTN_AUTO_REPEAT_EN
        // A repeat at edge t needs the synchronised input still high in the
        // cycle before t; after a 40-cycle hold that holds up to t0+42.
        for (int t = LAT + RD; t <= 40 + 2; t += RP) exp_en_q.push_back(t0 + t);
`endif
        cycles(40);
        bus.btn_step = 1'b0;
        cycles(20);
        check_val("s6_en_pending", exp_en_q.size(), 0);
        check_val("end_load_pending", exp_load_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
